mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter_pkg.sv | 13 +
 rtl/mux_rr_arbiter_mux4_data.sv | 25 ++
 rtl/mux_rr_arbiter.sv | 114 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin multiplexing arbiter: state
// encoding, requester count and owner-index width.
package mux_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

endpackage

// File: rtl/mux_rr_arbiter_mux4_data.sv
// W-bit 4:1 data selector driven by the arbiter's registered owner index.
module mux4_data
  import mux_rr_arbiter_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  input  logic [W-1:0]     d2,
  input  logic [W-1:0]     d3,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter with bounded hold time; the owner's
// data is routed to dout while a grant is active.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int W        = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  input  logic [W-1:0]     d2,
  input  logic [W-1:0]     d3,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic [W-1:0]     dout,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [SEL_W-1:0] pick;
  logic [SEL_W-1:0] idx;
  logic             found;
  logic             release_now;
  logic [W-1:0]     mux_y;

  // First requester at or above ptr, wrapping modulo NREQ.
  always_comb begin
    pick  = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr_q + SEL_W'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign release_now = done || !req[sel_q] || (cnt_q == 8'(MAX_HOLD - 1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          state_d = GRANT;
          sel_d   = pick;
          gnt_d   = NREQ'(1) << pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // Release always passes through IDLE, so a re-grant costs one gap cycle.
        if (release_now) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + SEL_W'(1);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  mux4_data #(.W(W)) u_mux (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (sel_q),
    .y   (mux_y)
  );

  assign busy = (state_q == GRANT);
  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign dout = busy ? mux_y : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: each cycle's expected {gnt,sel,busy,dout}
// is queued with its stimulus and popped once the clock edge has been taken.
module tb_mux_rr_arbiter;

  localparam int W        = 4;
  localparam int MAX_HOLD = 8;
  localparam int VW       = 4 + 2 + 1 + W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic         done;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] dout;
  logic         busy;

  logic [VW-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  mux_rr_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .gnt   (gnt),
    .sel   (sel),
    .dout  (dout),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dval(input int s);
    case (s)
      0:       return 4'h5;
      1:       return 4'hA;
      2:       return 4'h1;
      default: return 4'hC;
    endcase
  endfunction

  // Expected outputs: g=1 means owner s holds the grant, g=0 means idle with sel=s.
  function automatic logic [VW-1:0] ev(input bit g, input int s);
    logic [3:0] one;
    logic [1:0] s2;
    one = 4'b0001;
    s2  = 2'(s);
    if (g) return {one << s2, s2, 1'b1, dval(s)};
    return {4'b0000, s2, 1'b0, {W{1'b0}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req   = 4'b0000;
    done  = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [VW-1:0] e;
    apply_reset();
    e = ev(0, 0);
    n_assert++;
    if ({gnt, sel, busy, dout} !== e) begin
      n_fail++;
      $display("FAIL reset_state got %b expected %b", {gnt, sel, busy, dout}, e);
    end
  endtask

  // Single request to 2, done pulse, then ptr=3 makes 3 win over 0..2.
  task automatic test_basic();
    logic [3:0] rq[5] = '{4'b0100, 4'b0100, 4'b1111, 4'b0000, 4'b0000};
    bit         dn[5] = '{0, 1, 0, 0, 0};
    logic [VW-1:0] e;
    apply_reset();
    exp_q.push_back(ev(1, 2));
    exp_q.push_back(ev(0, 2));
    exp_q.push_back(ev(1, 3));
    exp_q.push_back(ev(0, 3));
    exp_q.push_back(ev(0, 3));
    for (int c = 0; c < 5; c++) begin
      req = rq[c]; done = dn[c];
      tick();
      e = exp_q.pop_front();
      n_assert++;
      if ({gnt, sel, busy, dout} !== e) begin
        n_fail++;
        $display("FAIL basic cyc%0d got %b expected %b", c, {gnt, sel, busy, dout}, e);
      end
    end
  endtask

  task automatic test_rotate();
    int owners[5] = '{0, 1, 2, 3, 0};
    logic [VW-1:0] e;
    apply_reset();
    req = 4'b1111;
    foreach (owners[i]) begin
      for (int c = 0; c < 3; c++) begin
        done = (c == 2);
        exp_q.push_back(ev(c != 2, owners[i]));
        tick();
        e = exp_q.pop_front();
        n_assert++;
        if ({gnt, sel, busy, dout} !== e) begin
          n_fail++;
          $display("FAIL rotate grant%0d cyc%0d got %b expected %b", i, c, {gnt, sel, busy, dout}, e);
        end
      end
    end
    done = 1'b0;
  endtask

  task automatic test_max_hold();
    logic [VW-1:0] e;
    apply_reset();
    req = 4'b0001; done = 1'b0;
    for (int c = 0; c < MAX_HOLD; c++) exp_q.push_back(ev(1, 0));
    exp_q.push_back(ev(0, 0));
    exp_q.push_back(ev(1, 0));
    for (int c = 0; c < MAX_HOLD + 2; c++) begin
      tick();
      e = exp_q.pop_front();
      n_assert++;
      if ({gnt, sel, busy, dout} !== e) begin
        n_fail++;
        $display("FAIL max_hold cyc%0d got %b expected %b", c, {gnt, sel, busy, dout}, e);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_wrap();
    logic [3:0] rq[4] = '{4'b1000, 4'b0001, 4'b0001, 4'b0000};
    logic [VW-1:0] e;
    apply_reset();
    exp_q.push_back(ev(1, 3));
    exp_q.push_back(ev(0, 3));
    exp_q.push_back(ev(1, 0));
    exp_q.push_back(ev(0, 0));
    for (int c = 0; c < 4; c++) begin
      req = rq[c];
      tick();
      e = exp_q.pop_front();
      n_assert++;
      if ({gnt, sel, busy, dout} !== e) begin
        n_fail++;
        $display("FAIL wrap cyc%0d got %b expected %b", c, {gnt, sel, busy, dout}, e);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [VW-1:0] e;
    apply_reset();
    req = 4'b1000;
    exp_q.push_back(ev(1, 3));
    tick();
    e = exp_q.pop_front();
    n_assert++;
    if ({gnt, sel, busy, dout} !== e) begin
      n_fail++;
      $display("FAIL midrst_pre got %b expected %b", {gnt, sel, busy, dout}, e);
    end
    #1 rst_n = 1'b0;
    #1;
    e = ev(0, 0);
    n_assert++;
    if ({gnt, sel, busy, dout} !== e) begin
      n_fail++;
      $display("FAIL midrst_async got %b expected %b", {gnt, sel, busy, dout}, e);
    end
    rst_n = 1'b1;
    req = 4'b1010;
    exp_q.push_back(ev(1, 1));
    tick();
    e = exp_q.pop_front();
    n_assert++;
    if ({gnt, sel, busy, dout} !== e) begin
      n_fail++;
      $display("FAIL midrst_regrant got %b expected %b", {gnt, sel, busy, dout}, e);
    end
    req = 4'b0000;
    exp_q.push_back(ev(0, 1));
    tick();
    e = exp_q.pop_front();
    n_assert++;
    if ({gnt, sel, busy, dout} !== e) begin
      n_fail++;
      $display("FAIL midrst_release got %b expected %b", {gnt, sel, busy, dout}, e);
    end
  endtask

  task automatic test_done_in_idle();
    bit dn[3] = '{1, 0, 0};
    logic [3:0] rq[3] = '{4'b0010, 4'b0010, 4'b0000};
    logic [VW-1:0] e;
    apply_reset();
    exp_q.push_back(ev(1, 1));
    exp_q.push_back(ev(1, 1));
    exp_q.push_back(ev(0, 1));
    for (int c = 0; c < 3; c++) begin
      req = rq[c]; done = dn[c];
      tick();
      e = exp_q.pop_front();
      n_assert++;
      if ({gnt, sel, busy, dout} !== e) begin
        n_fail++;
        $display("FAIL done_idle cyc%0d got %b expected %b", c, {gnt, sel, busy, dout}, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    d0 = dval(0); d1 = dval(1); d2 = dval(2); d3 = dval(3);
    test_reset();
    test_basic();
    test_rotate();
    test_max_hold();
    test_wrap();
    test_reset_mid_grant();
    test_done_in_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
